// File: rtl/cmp_sweep_driver.sv
// Sweeps every (row, col) select pair of a compare responder and collects the
// returned bits into a result vector. Pairs that never answer are flagged.
`timescale 1ns/1ps
module cmp_sweep_driver #(
    parameter int ROW_W   = 2,
    parameter int COL_W   = 2,
    parameter int TIMEOUT = 15,
    localparam int N      = 2**(ROW_W+COL_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N-1:0]     mask,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [ROW_W-1:0] row_sel,
    output logic [COL_W-1:0] col_sel,
    input  logic             rsp_valid,
    input  logic             rsp_bit,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [N-1:0]     result,
    output logic [N-1:0]     timeout_err
);
    localparam int IW = ROW_W + COL_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [N-1:0]  result_q, result_d;
    logic [N-1:0]  terr_q, terr_d;
    logic          aborted_q, aborted_d;
    logic          adv;
    logic          last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            result_q  <= '0;
            terr_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            result_q  <= result_d;
            terr_q    <= terr_d;
            aborted_q <= aborted_d;
        end
    end

    assign last = (idx_q == IW'(N-1));

    // Handshake: req_valid rises in ISSUE for an enabled pair and holds, with
    // stable selects, until the cycle where req_ready is also 1; that cycle is
    // the transfer. req_valid never depends combinationally on any input.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        result_d  = result_q;
        terr_d    = terr_q;
        aborted_d = 1'b0;
        adv       = 1'b0;
        req_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d   = mask;
                    result_d = '0;
                    terr_d   = '0;
                    idx_d    = '0;
                    cnt_d    = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                req_valid = mask_q[idx_q];
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (!mask_q[idx_q]) begin
                    result_d[idx_q] = 1'b0;
                    adv             = 1'b1;
                end else if (req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (rsp_valid) begin
                    // A response on the final allowed cycle still wins.
                    result_d[idx_q] = rsp_bit;
                    adv             = 1'b1;
                end else if (cnt_q == 8'(TIMEOUT-1)) begin
                    result_d[idx_q] = 1'b0;
                    terr_d[idx_q]   = 1'b1;
                    adv             = 1'b1;
                end
            end
            DONE: begin
                aborted_d = abort;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            cnt_d = '0;
            if (last) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q + IW'(1);
                state_d = ISSUE;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign aborted     = aborted_q;
    assign row_sel     = idx_q[IW-1:COL_W];
    assign col_sel     = idx_q[COL_W-1:0];
    assign result      = result_q;
    assign timeout_err = terr_q;

endmodule
